// File: rtl/cim_sample_ctl.sv
// Sample-period timer and frame-capture controller for a cascaded-integrator bank.
// Optional overrun counter port ovr_count is built when CIM_CTL_OVR_COUNT_EN is defined.
module cim_sample_ctl #(
  parameter int dw    = 32,
  parameter int nchan = 12,
  parameter int pw    = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [pw-1:0] period,
  output logic          sample,
  input  logic [dw-1:0] sr_in,
  input  logic          sr_val,
  output logic          ready,
  input  logic          ack,
  input  logic [3:0]    rd_addr,
  output logic [dw-1:0] rd_data,
  output logic          overrun,
  input  logic          clr_ovr
`ifdef CIM_CTL_OVR_COUNT_EN
  ,
  output logic [7:0]    ovr_count
`endif
);

  localparam int aw = $clog2(nchan);
  localparam logic [pw-1:0] min_per   = pw'(2 * nchan - 1);
  localparam logic [aw-1:0] last_wptr = aw'(nchan - 1);
  localparam logic [3:0]    last_addr = 4'(nchan - 1);

  typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_t;

  state_t        state, state_nx;
  logic [pw-1:0] cnt;
  logic [pw-1:0] eff;
  logic [aw-1:0] wptr, wptr_nx;
  logic          wr_en;
  logic          ovr_evt;
  logic [dw-1:0] mem [nchan];

  // Floor on the interval guarantees a full shift-out fits between snapshots.
  always_comb begin
    eff = (period > min_per) ? period : min_per;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= eff;
      sample <= 1'b0;
    end else if (!enable) begin
      cnt    <= eff;
      sample <= 1'b0;
    end else if (cnt == '0) begin
      cnt    <= eff;
      sample <= 1'b1;
    end else begin
      cnt    <= cnt - pw'(1);
      sample <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wptr  <= '0;
    end else begin
      state <= state_nx;
      wptr  <= wptr_nx;
    end
  end

  // A frame is dropped only when a snapshot arrives while the buffer is still
  // held and the host has not released it in the same cycle.
  always_comb begin
    state_nx = state;
    wptr_nx  = wptr;
    wr_en    = 1'b0;
    ovr_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (sample) begin
          state_nx = CAPT;
          wptr_nx  = '0;
        end
      end
      CAPT: begin
        if (sr_val) begin
          wr_en = 1'b1;
          if (wptr == last_wptr) begin
            state_nx = HOLD;
            wptr_nx  = '0;
          end else begin
            wptr_nx = wptr + aw'(1);
          end
        end
      end
      HOLD: begin
        if (ack) begin
          state_nx = sample ? CAPT : IDLE;
          wptr_nx  = '0;
        end else if (sample) begin
          ovr_evt = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        wptr_nx  = '0;
      end
    endcase
  end

  assign ready = (state == HOLD);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= sr_in;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if (rd_addr <= last_addr)
      rd_data <= mem[rd_addr[aw-1:0]];
    else
      rd_data <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      overrun <= 1'b0;
    else if (ovr_evt)
      overrun <= 1'b1;
    else if (clr_ovr)
      overrun <= 1'b0;
  end

`ifdef CIM_CTL_OVR_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      ovr_count <= '0;
    else if (ovr_evt)
      ovr_count <= clr_ovr ? 8'd1 : ((ovr_count == '1) ? ovr_count : ovr_count + 8'd1);
    else if (clr_ovr)
      ovr_count <= '0;
  end
`endif

endmodule

// File: tb/tb_cim_sample_ctl.sv
// Directed bench for cim_sample_ctl: timer spacing, period clamp, capture,
// overrun, ack collision and reset during capture.
module tb_cim_sample_ctl;

  logic        clk = 1'b0;
  logic        reset, enable, sr_val, ack, clr_ovr;
  logic [23:0] period;
  logic [31:0] sr_in, rd_data;
  logic [3:0]  rd_addr;
  logic        sample, ready, overrun;
`ifdef CIM_CTL_OVR_COUNT_EN
  logic [7:0]  ovr_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cim_sample_ctl #(.dw(32), .nchan(12), .pw(24)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .sample(sample), .sr_in(sr_in), .sr_val(sr_val), .ready(ready),
    .ack(ack), .rd_addr(rd_addr), .rd_data(rd_data), .overrun(overrun),
    .clr_ovr(clr_ovr)
`ifdef CIM_CTL_OVR_COUNT_EN
    , .ovr_count(ovr_count)
`endif
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t rv [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sample(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample && n < 2000);
    if (!sample) chk("sample_timeout", 32'(n), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic feed(input int count, input int base);
    for (int k = 0; k < count; k++) begin
      sr_val = 1'b1;
      sr_in  = 32'(base + k);
      tick();
    end
    sr_val = 1'b0;
    sr_in  = '0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
    rd_addr = a;
    tick();
    chk(name, rd_data, exp);
  endtask

  int n;

  initial begin
    reset = 1'b1; enable = 1'b0; sr_val = 1'b0; ack = 1'b0; clr_ovr = 1'b0;
    period = 24'd99; sr_in = '0; rd_addr = '0;

    // reset values
    do_reset();
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // enable low: no strobe
    repeat (150) begin
      tick();
      if (sample) chk("idle_sample", 32'(sample), 32'd0);
    end

    // period 99 -> pulses every 100 cycles, each one cycle wide
    enable = 1'b1;
    wait_sample(n);
    chk("first_sample_dly", 32'(n), 32'd100);
    for (int p = 0; p < 2; p++) begin
      tick();
      chk("sample_width", 32'(sample), 32'd0);
      wait_sample(n);
      chk("sample_interval", 32'(n + 1), 32'd100);
    end

    // clamp: period 5 -> interval 24
    enable = 1'b0;
    period = 24'd5;
    do_reset();
    enable = 1'b1;
    wait_sample(n);
    chk("clamp_first", 32'(n), 32'd24);
    tick();
    wait_sample(n);
    chk("clamp_interval", 32'(n + 1), 32'd24);

    // capture a frame of 1..12
    enable = 1'b0;
    period = 24'd99;
    do_reset();
    enable = 1'b1;
    wait_sample(n);
    tick();
    chk("cap_sample_low", 32'(sample), 32'd0);
    chk("cap_ready_low", 32'(ready), 32'd0);
    feed(12, 1);
    chk("cap_ready", 32'(ready), 32'd1);
    feed(3, 32'hDEAD);  // stray words while holding
    chk("ack_outside_hold_ignored_pre", 32'(ready), 32'd1);

    for (int i = 0; i < 12; i++) rv[i] = '{addr: 4'(i), exp: 32'(i + 1)};
    rv[12] = '{addr: 4'd13, exp: 32'd0};
    rv[13] = '{addr: 4'd15, exp: 32'd0};
    for (int i = 0; i < 14; i++) begin
      rd_addr = rv[i].addr;
      tick();
      chk($sformatf("rd_addr_%0d", rv[i].addr), rd_data, rv[i].exp);
    end

    // overrun: next strobe arrives with no ack
    wait_sample(n);
    tick();
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_ready_held", 32'(ready), 32'd1);
`ifdef CIM_CTL_OVR_COUNT_EN
    chk("ovr_count_1", 32'(ovr_count), 32'd1);
`endif
    feed(12, 100);
    rd("ovr_buf0", 4'd0, 32'd1);
    rd("ovr_buf11", 4'd11, 32'd12);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
`ifdef CIM_CTL_OVR_COUNT_EN
    chk("ovr_count_clr", 32'(ovr_count), 32'd0);
`endif

    // clear coincident with a new drop: set wins
    wait_sample(n);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr2", 32'(overrun), 32'd0);

    // ack coincident with strobe: new frame captured, no overrun
    wait_sample(n);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("coll_ready_low", 32'(ready), 32'd0);
    chk("coll_no_ovr", 32'(overrun), 32'd0);
    feed(12, 201);
    chk("coll_ready", 32'(ready), 32'd1);
    rd("coll_buf0", 4'd0, 32'd201);
    rd("coll_buf11", 4'd11, 32'd212);
    chk("coll_no_ovr2", 32'(overrun), 32'd0);

    // plain ack releases the buffer one cycle later; later ack is ignored
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_release", 32'(ready), 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_idle_ignored", 32'(ready), 32'd0);

    // reset after 5 of 12 words
    wait_sample(n);
    tick();
    feed(5, 500);
    do_reset();
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_wptr", 32'(dut.wptr), 32'd0);
    wait_sample(n);
    chk("midrst_restart_dly", 32'(n), 32'd100);
    tick();
    feed(4, 301);
    enable = 1'b0;  // capture must still complete
    feed(8, 305);
    chk("midrst_ready2", 32'(ready), 32'd1);
    rd("midrst_buf0", 4'd0, 32'd301);
    rd("midrst_buf4", 4'd4, 32'd305);
    rd("midrst_buf11", 4'd11, 32'd312);
    repeat (120) begin
      tick();
      if (sample) chk("disabled_sample", 32'(sample), 32'd0);
    end
    chk("disabled_no_ovr", 32'(overrun), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cim_sample_ctl.md
CIM_SAMPLE_CTL -- requirements
Module: cim_sample_ctl

Interface
REQ-001 The block SHALL have these parameters:
- dw, 32, sample word width; matches the cascaded-integrator shift-out width.
- nchan, 12, number of words per frame.
- pw, 24, width of the period register.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: run the sample-period timer.
- period, in, pw: sample interval minus 1, in clk cycles.
- sample, out, 1: one-cycle snapshot strobe to the integrator bank.
- sr_in, in, dw: shift-out data from the integrator bank.
- sr_val, in, 1: shift-out gate; sr_in is valid when high.
- ready, out, 1: frame buffer holds a complete, unacknowledged frame.
- ack, in, 1: host releases the frame buffer.
- rd_addr, in, 4: frame word index.
- rd_data, out, dw: frame word at rd_addr, registered.
- overrun, out, 1: sticky; a frame was dropped.
- clr_ovr, in, 1: clears overrun.

Function
REQ-003 The timer SHALL count down from the effective period and assert sample for exactly one cycle when it reaches 0 with enable high, then reload.
REQ-004 The effective period SHALL be max(period, 2*nchan-1), so a capture always completes before the next sample.
REQ-005 The first sample after enable rises SHALL occur effective period+1 cycles later.
REQ-006 A period change SHALL take effect only at the next reload.
REQ-007 With enable low, the timer SHALL hold at reload value and sample SHALL stay 0.
REQ-008 The capture FSM SHALL have these states:
- IDLE: go to CAPT on sample if ready=0 (or ack same cycle); otherwise stay, set overrun.
- CAPT: write sr_in to buffer[wptr] on each sr_val cycle, wptr++; when wptr reaches nchan, go to HOLD.
- HOLD: ready=1; on ack go to IDLE, and ready=0 the next cycle.
REQ-009 Words arriving with sr_val while in IDLE or HOLD SHALL be discarded, and buffer contents SHALL be preserved.
REQ-010 wptr SHALL reset to 0 on entry to CAPT and SHALL never exceed nchan-1 as a write index.
REQ-011 When ack and sample occur in the same cycle in HOLD, ack SHALL win: the next frame is captured and overrun is not set.
REQ-012 An ack outside HOLD SHALL be ignored.
REQ-013 When enable falls during CAPT, the capture SHALL complete normally.
REQ-014 rd_data SHALL equal buffer[rd_addr] one cycle after rd_addr is presented; rd_addr >= nchan SHALL return 0.
REQ-015 When clr_ovr and a new overrun event occur in the same cycle, overrun SHALL remain 1 (set wins).

Reset
REQ-016 Reset SHALL be synchronous and active-high, with these values:
- sample=0, ready=0, rd_data=0, overrun=0.
- FSM in IDLE, wptr=0, timer at reload value.
REQ-017 Buffer RAM SHALL not be reset.
REQ-018 Reset during CAPT SHALL abandon the frame, and ready SHALL stay 0.

Configuration
REQ-019 Macro CIM_CTL_OVR_COUNT_EN SHALL control an overrun counter:
- Defined: add output ovr_count[7:0], incremented per dropped frame, saturating at 255, cleared by clr_ovr or reset.
- Undefined: the port and counter SHALL be absent; overrun behaviour is unchanged.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Timing: reset, enable=1, period=99 -> sample pulses at cycles 100, 200, 300 after enable; each is exactly 1 cycle wide.
- Clamp: period=5, nchan=12 -> sample interval is 24 cycles.
- Capture: sample, then 12 sr_val cycles with sr_in=k+1 -> ready=1; rd_addr=0..11 return 1..12 with 1-cycle latency; rd_addr=13 returns 0.
- Overrun: no ack before the next sample -> overrun=1, buffer unchanged, ovr_count=1 if the macro is defined; clr_ovr -> overrun=0.
- Ack collision: ack coincident with sample -> new frame captured, overrun stays 0.
- Reset mid-capture: reset after 5 of 12 words -> ready=0, wptr=0, and the next full frame captures correctly.
